regfile_wb_scoreboard: RTL and testbench

- Stage-2 register file: the receiving end of the writeback path driven from stage 5.
- Holds 32x32-bit GPRs and provides two registered read ports.
- Keeps a per-register pending-write scoreboard so decode stalls on RAW hazards until the producing writeback lands.
- Consumes do_wb/wb_reg/wb_val from stage 5 and issue notifications from decode.

---
 rtl/regfile_wb_if.sv | 31 +++
 rtl/regfile_wb_scoreboard.sv | 103 ++++++++++
 tb/tb_regfile_wb_scoreboard.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_if.sv
// Decode/writeback bus of the stage-2 register file: writeback and issue inputs,
// read addresses, registered read data, busy/stall and the sticky error flag.
interface regfile_wb_if;
    logic        do_wb_i;
    logic [4:0]  wb_reg_i;
    logic [31:0] wb_val_i;
    logic        issue_i;
    logic [4:0]  issue_reg_i;
    logic [4:0]  ra_reg_i;
    logic [4:0]  rb_reg_i;
    logic        ra_use_i;
    logic        rb_use_i;
    logic [31:0] ra_val_o;
    logic [31:0] rb_val_o;
    logic        ra_busy_o;
    logic        rb_busy_o;
    logic        stall_o;
    logic        sb_err_o;

    modport master (
        output do_wb_i, wb_reg_i, wb_val_i, issue_i, issue_reg_i,
               ra_reg_i, rb_reg_i, ra_use_i, rb_use_i,
        input  ra_val_o, rb_val_o, ra_busy_o, rb_busy_o, stall_o, sb_err_o
    );

    modport slave (
        input  do_wb_i, wb_reg_i, wb_val_i, issue_i, issue_reg_i,
               ra_reg_i, rb_reg_i, ra_use_i, rb_use_i,
        output ra_val_o, rb_val_o, ra_busy_o, rb_busy_o, stall_o, sb_err_o
    );
endinterface

// File: rtl/regfile_wb_scoreboard.sv
// Stage-2 GPR file (32x32, two registered read ports) with a per-register pending-write
// scoreboard for RAW stalls. Optional macro REGFILE_BYPASS_EN enables writeback-to-read bypass.
module regfile_wb_scoreboard #(
    parameter int unsigned CNT_W = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    regfile_wb_if.slave  bus
);
    localparam int unsigned NREG = 32;
    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 5;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [XLEN-1:0]  regs    [NREG];
    logic [CNT_W-1:0] cnt     [NREG];
    logic [CNT_W-1:0] cnt_nxt [NREG];
    logic [NREG-1:0]  busy;
    logic             err_set;
    logic             wr_en;
    logic [XLEN-1:0]  ra_rd;
    logic [XLEN-1:0]  rb_rd;

    assign wr_en = bus.do_wb_i && (bus.wb_reg_i != '0);

    // Next pending count per register; simultaneous issue and writeback cancel out.
    always_comb begin
        err_set = 1'b0;
        for (int unsigned r = 0; r < NREG; r++) begin
            cnt_nxt[AW'(r)] = cnt[AW'(r)];
        end
        for (int unsigned r = 1; r < NREG; r++) begin
            if (bus.issue_i && (bus.issue_reg_i == AW'(r)) &&
                !(bus.do_wb_i && (bus.wb_reg_i == AW'(r)))) begin
                if (cnt[AW'(r)] == CNT_MAX) begin
                    err_set = 1'b1;
                end else begin
                    cnt_nxt[AW'(r)] = cnt[AW'(r)] + CNT_W'(1);
                end
            end else if (bus.do_wb_i && (bus.wb_reg_i == AW'(r)) &&
                         !(bus.issue_i && (bus.issue_reg_i == AW'(r)))) begin
                if (cnt[AW'(r)] == '0) begin
                    err_set = 1'b1;
                end else begin
                    cnt_nxt[AW'(r)] = cnt[AW'(r)] - CNT_W'(1);
                end
            end
        end
    end

    // Busy vector; r0 never busy.
    always_comb begin
        busy = '0;
        for (int unsigned r = 1; r < NREG; r++) begin
            busy[AW'(r)] = (cnt[AW'(r)] != '0);
`ifdef REGFILE_BYPASS_EN
            if (wr_en && (bus.wb_reg_i == AW'(r)) && (cnt[AW'(r)] == CNT_W'(1))) begin
                busy[AW'(r)] = 1'b0;
            end
`endif
        end
    end

    assign bus.ra_busy_o = busy[bus.ra_reg_i];
    assign bus.rb_busy_o = busy[bus.rb_reg_i];
    assign bus.stall_o   = (bus.ra_use_i & bus.ra_busy_o) | (bus.rb_use_i & bus.rb_busy_o);

    // Read-port source selection, optionally writing through the retiring value.
    always_comb begin
        ra_rd = regs[bus.ra_reg_i];
        rb_rd = regs[bus.rb_reg_i];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (bus.wb_reg_i == bus.ra_reg_i)) ra_rd = bus.wb_val_i;
        if (wr_en && (bus.wb_reg_i == bus.rb_reg_i)) rb_rd = bus.wb_val_i;
`endif
        if (bus.ra_reg_i == '0) ra_rd = '0;
        if (bus.rb_reg_i == '0) rb_rd = '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                regs[AW'(r)] <= '0;
                cnt[AW'(r)]  <= '0;
            end
            bus.ra_val_o <= '0;
            bus.rb_val_o <= '0;
            bus.sb_err_o <= 1'b0;
        end else begin
            if (wr_en) begin
                regs[bus.wb_reg_i] <= bus.wb_val_i;
            end
            for (int unsigned r = 0; r < NREG; r++) begin
                cnt[AW'(r)] <= cnt_nxt[AW'(r)];
            end
            bus.ra_val_o <= ra_rd;
            bus.rb_val_o <= rb_rd;
            if (err_set) begin
                bus.sb_err_o <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_regfile_wb_scoreboard.sv
// Bench for regfile_wb_scoreboard: directed scenarios plus random traffic against a
// behavioural model of registers, pending counts and the error flag.
module tb_regfile_wb_scoreboard;
    localparam int unsigned CNT_W = 2;
    localparam int CMAX = (1 << CNT_W) - 1;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    regfile_wb_if bus ();

    regfile_wb_scoreboard #(.CNT_W(CNT_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    bit          armed    = 1'b0;
    logic [31:0] m_regs [32];
    int          m_cnt  [32];
    bit          m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic bit m_busy(input logic [4:0] r);
        if (r == 5'd0 || m_cnt[r] == 0) return 1'b0;
        if (BYPASS && bus.do_wb_i && bus.wb_reg_i == r && m_cnt[r] == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (BYPASS && bus.do_wb_i && bus.wb_reg_i == a) return bus.wb_val_i;
        return m_regs[a];
    endfunction

    task automatic drive(input bit w, input logic [4:0] wr, input logic [31:0] wv,
                         input bit is, input logic [4:0] ir,
                         input logic [4:0] a, input logic [4:0] b, input bit au, input bit bu);
        bus.do_wb_i     = w;
        bus.wb_reg_i    = wr;
        bus.wb_val_i    = wv;
        bus.issue_i     = is;
        bus.issue_reg_i = ir;
        bus.ra_reg_i    = a;
        bus.rb_reg_i    = b;
        bus.ra_use_i    = au;
        bus.rb_use_i    = bu;
    endtask

    task automatic peek_stall(input string tag, input bit exp);
        #1;
        check(tag, 32'(bus.stall_o), 32'(exp));
    endtask

    // One clock: check combinational outputs, advance the model, check registered outputs.
    task automatic tick();
        logic [31:0] exp_ra, exp_rb;
        bit ba, bb, inc, dec;
        #1;
        if (armed) begin
            ba = m_busy(bus.ra_reg_i);
            bb = m_busy(bus.rb_reg_i);
            check("ra_busy", 32'(bus.ra_busy_o), 32'(ba));
            check("rb_busy", 32'(bus.rb_busy_o), 32'(bb));
            check("stall", 32'(bus.stall_o), 32'((bus.ra_use_i & ba) | (bus.rb_use_i & bb)));
        end
        if (rst) begin
            foreach (m_regs[i]) begin m_regs[i] = 32'd0; m_cnt[i] = 0; end
            m_err  = 1'b0;
            exp_ra = 32'd0;
            exp_rb = 32'd0;
        end else begin
            exp_ra = m_read(bus.ra_reg_i);
            exp_rb = m_read(bus.rb_reg_i);
            for (int r = 1; r < 32; r++) begin
                inc = bus.issue_i && (int'(bus.issue_reg_i) == r);
                dec = bus.do_wb_i && (int'(bus.wb_reg_i) == r);
                if (inc && !dec) begin
                    if (m_cnt[r] == CMAX) m_err = 1'b1;
                    else m_cnt[r]++;
                end else if (dec && !inc) begin
                    if (m_cnt[r] == 0) m_err = 1'b1;
                    else m_cnt[r]--;
                end
            end
            if (bus.do_wb_i && bus.wb_reg_i != 5'd0) m_regs[bus.wb_reg_i] = bus.wb_val_i;
        end
        @(posedge clk);
        #1;
        armed = 1'b1;
        check("ra_val", bus.ra_val_o, exp_ra);
        check("rb_val", bus.rb_val_o, exp_rb);
        check("sb_err", 32'(bus.sb_err_o), 32'(m_err));
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Post-reset reads
        drive(0, 0, 0, 0, 0, 5, 0, 1, 1);
        peek_stall("t1_stall", 1'b0);
        tick();
        check("t1_ra", bus.ra_val_o, 32'd0);
        check("t1_err", 32'(bus.sb_err_o), 32'd0);

        // Plain write/read and r0
        drive(1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 3, 0, 0, 0);
        tick();
        check("t2_r3", bus.ra_val_o, 32'hDEADBEEF);
        drive(1, 0, 32'h1234, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check("t2_r0", bus.ra_val_o, 32'd0);

        // RAW stall on r7
        drive(0, 0, 0, 1, 7, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 7, 0, 1, 0);
        peek_stall("t3_stall_pend", 1'b1);
        tick();
        tick();
        drive(1, 7, 32'h55, 0, 0, 7, 0, 1, 0);
        peek_stall("t3_stall_wb", !BYPASS);
        tick();
        if (BYPASS) check("t3_bypass", bus.ra_val_o, 32'h55);
        drive(0, 0, 0, 0, 0, 7, 0, 1, 0);
        peek_stall("t3_stall_after", 1'b0);
        tick();
        check("t3_ra", bus.ra_val_o, 32'h55);

        // Multiple in-flight writes to r9
        drive(0, 0, 0, 1, 9, 0, 0, 0, 0);
        tick();
        tick();
        drive(1, 9, 32'h91, 1, 9, 0, 0, 0, 0);
        tick();
        drive(1, 9, 32'h92, 0, 0, 9, 0, 1, 0);
        peek_stall("t4_cnt2", 1'b1);
        tick();
        drive(1, 9, 32'h93, 0, 0, 9, 0, 1, 0);
        peek_stall("t4_cnt1", !BYPASS);
        tick();
        drive(0, 0, 0, 0, 0, 9, 0, 1, 0);
        peek_stall("t4_cnt0", 1'b0);
        tick();
        check("t4_r9", bus.ra_val_o, 32'h93);

        // Underflow, saturation, reset clears
        drive(1, 4, 32'h44, 0, 0, 0, 0, 0, 0);
        tick();
        check("t5_underflow", 32'(bus.sb_err_o), 32'd1);
        drive(0, 0, 0, 1, 4, 4, 0, 0, 0);
        repeat (4) tick();
        check("t5_sat_err", 32'(bus.sb_err_o), 32'd1);
        check("t5_r4_data", bus.ra_val_o, 32'h44);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 4, 0, 1, 0);
        tick();
        rst = 1'b0;
        peek_stall("t5_rst_busy", 1'b0);
        tick();
        check("t5_rst_err", 32'(bus.sb_err_o), 32'd0);
        check("t5_rst_r4", bus.ra_val_o, 32'd0);

        // Issue and writeback to r2 in the same cycle
        drive(0, 0, 0, 1, 2, 0, 0, 0, 0);
        tick();
        drive(1, 2, 32'hA5A5A5A5, 1, 2, 2, 2, 1, 1);
        peek_stall("t6_stall_wb", !BYPASS);
        tick();
        if (BYPASS) begin
            check("t6_bypass_a", bus.ra_val_o, 32'hA5A5A5A5);
            check("t6_bypass_b", bus.rb_val_o, 32'hA5A5A5A5);
        end
        drive(0, 0, 0, 0, 0, 2, 2, 1, 1);
        peek_stall("t6_still_busy", 1'b1);
        tick();
        check("t6_ra", bus.ra_val_o, 32'hA5A5A5A5);
        check("t6_rb", bus.rb_val_o, 32'hA5A5A5A5);

        // Random traffic on a small register window to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 255) == 0);
            drive($urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  1'($urandom), 1'($urandom));
            tick();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
